// File: rtl/ecs8_ef_pkg.sv
// Shared types and helpers for the Flash/Ethernet external bus controller.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package ecs8_ef_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        TURN  = 3'd4
    } state_t;

    typedef enum logic {
        FL = 1'b0,
        EN = 1'b1
    } dev_t;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ecs8_ef_arb.sv
// Two-way round-robin grant between the flash and ethernet requesters.
// Latency: grant is combinational; the round-robin pointer updates on the edge a grant is taken.
// Backpressure: none of its own; the sequencer only takes a grant while idle.
module ecs8_ef_arb
    import ecs8_ef_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic fl_req,
    input  logic en_req,
    input  logic take,
    output logic gnt_vld,
    output dev_t gnt_dev
);

    dev_t last;

    // Pick the device that was not served last when both are asking.
    always_comb begin
        gnt_vld = fl_req | en_req;
        gnt_dev = FL;
        if (fl_req && en_req) begin
            gnt_dev = (last == FL) ? EN : FL;
        end else if (en_req) begin
            gnt_dev = EN;
        end
    end

    // Remember who was granted; reset to EN so flash wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= EN;
        end else if (take && gnt_vld) begin
            last <= gnt_dev;
        end
    end

endmodule

// File: rtl/ecs8_ef_bus_ctrl.sv
// Arbiter and setup/pulse/hold strobe sequencer for the shared Flash/Ethernet bus.
// Latency: ack in last HOLD cycle, 1+SU+PW+HD cycles after req is seen in IDLE; reads add TA turnaround.
// Backpressure: a requester holds req and its fields until ack; the loser of arbitration waits.
module ecs8_ef_bus_ctrl
    import ecs8_ef_pkg::*;
#(
    parameter int AW    = 26,
    parameter int DW    = 32,
    parameter int FL_SU = 2,
    parameter int FL_PW = 4,
    parameter int FL_HD = 1,
    parameter int EN_SU = 1,
    parameter int EN_PW = 3,
    parameter int EN_HD = 1,
    parameter int TA    = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          fl_req,
    input  logic          fl_we,
    input  logic [AW-1:0] fl_adr,
    input  logic [DW-1:0] fl_wdt,
    output logic          fl_ack,
    output logic [DW-1:0] fl_rdt,
    input  logic          en_req,
    input  logic          en_we,
    input  logic [AW-1:0] en_adr,
    input  logic [DW-1:0] en_wdt,
    input  logic [3:0]    en_be,
    output logic          en_ack,
    output logic [DW-1:0] en_rdt,
    output logic [AW-1:0] ef_a,
    output logic [DW-1:0] ef_d_o,
    output logic          ef_d_e,
    input  logic [DW-1:0] ef_d_i,
    output logic          flash_ce_n,
    output logic          flash_oe_n,
    output logic          flash_we_n,
    output logic          enet_rd_n,
    output logic          enet_wr_n,
    output logic [3:0]    enet_be_n
);

    typedef struct packed {
        dev_t          dev;
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdt;
        logic [3:0]    be;
    } xfer_t;

    localparam logic [CNT_W-1:0] FL_SU_LD = cnt_load(FL_SU);
    localparam logic [CNT_W-1:0] FL_PW_LD = cnt_load(FL_PW);
    localparam logic [CNT_W-1:0] FL_HD_LD = cnt_load(FL_HD);
    localparam logic [CNT_W-1:0] EN_SU_LD = cnt_load(EN_SU);
    localparam logic [CNT_W-1:0] EN_PW_LD = cnt_load(EN_PW);
    localparam logic [CNT_W-1:0] EN_HD_LD = cnt_load(EN_HD);
    localparam logic [CNT_W-1:0] TA_LD    = cnt_load(TA);
    localparam bit               HAS_TURN = (TA > 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    xfer_t            cur;
    xfer_t            cur_nxt;

    logic             gnt_vld;
    dev_t             gnt_dev;

    logic             busy;
    logic             strobe;
    logic             last_hold;
    logic             is_fl;
    logic             rd_sample;
    logic [DW-1:0]    d_o_nxt;

    ecs8_ef_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .fl_req  (fl_req),
        .en_req  (en_req),
        .take    (state == IDLE),
        .gnt_vld (gnt_vld),
        .gnt_dev (gnt_dev)
    );

    // State, phase counter and latched transfer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cur   <= cur_nxt;
        end
    end

    // Next state: walk the phases, reloading the counter on each phase entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cur_nxt   = cur;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    cur_nxt.dev = gnt_dev;
                    if (gnt_dev == FL) begin
                        cur_nxt.we  = fl_we;
                        cur_nxt.adr = fl_adr;
                        cur_nxt.wdt = fl_wdt;
                        cur_nxt.be  = 4'hF;
                        cnt_nxt     = FL_SU_LD;
                    end else begin
                        cur_nxt.we  = en_we;
                        cur_nxt.adr = en_adr;
                        cur_nxt.wdt = en_wdt;
                        cur_nxt.be  = en_be;
                        cnt_nxt     = EN_SU_LD;
                    end
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = (cur.dev == FL) ? FL_PW_LD : EN_PW_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = (cur.dev == FL) ? FL_HD_LD : EN_HD_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (!cur.we && HAS_TURN) begin
                        state_nxt = TURN;
                        cnt_nxt   = TA_LD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            TURN: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pin values for the upcoming cycle, derived from where the FSM is heading.
    always_comb begin
        busy      = (state_nxt == SETUP) || (state_nxt == PULSE) || (state_nxt == HOLD);
        strobe    = (state_nxt == PULSE);
        last_hold = (state_nxt == HOLD) && (cnt_nxt == '0);
        is_fl     = (cur_nxt.dev == FL);
        rd_sample = (state == PULSE) && (cnt == '0) && !cur.we;
        d_o_nxt   = ef_d_o;
        if ((state == IDLE) && gnt_vld && cur_nxt.we) begin
            d_o_nxt = cur_nxt.wdt;
        end
    end

    // Registered pins, acks and read-data capture; reset drops every strobe at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ef_a       <= '0;
            ef_d_o     <= '0;
            ef_d_e     <= 1'b0;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            enet_rd_n  <= 1'b1;
            enet_wr_n  <= 1'b1;
            enet_be_n  <= 4'hF;
            fl_ack     <= 1'b0;
            en_ack     <= 1'b0;
            fl_rdt     <= '0;
            en_rdt     <= '0;
        end else begin
            ef_a       <= cur_nxt.adr;
            ef_d_o     <= d_o_nxt;
            ef_d_e     <= busy && cur_nxt.we;
            flash_ce_n <= !(busy && is_fl);
            flash_oe_n <= !(strobe && is_fl && !cur_nxt.we);
            flash_we_n <= !(strobe && is_fl && cur_nxt.we);
            enet_rd_n  <= !(strobe && !is_fl && !cur_nxt.we);
            enet_wr_n  <= !(strobe && !is_fl && cur_nxt.we);
            enet_be_n  <= (busy && !is_fl) ? ~cur_nxt.be : 4'hF;
            fl_ack     <= last_hold && is_fl;
            en_ack     <= last_hold && !is_fl;
            if (rd_sample) begin
                if (cur.dev == FL) begin
                    fl_rdt <= ef_d_i;
                end else begin
                    en_rdt <= ef_d_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_ecs8_ef_bus_ctrl.sv
// Bench for the shared Flash/Ethernet bus controller.
// Latency: n/a (bench).
// Backpressure: requesters hold req and fields until their ack is observed.
module tb_ecs8_ef_bus_ctrl;

    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int FL_SU = 2;
    localparam int FL_PW = 4;
    localparam int FL_HD = 1;
    localparam int EN_SU = 1;
    localparam int EN_PW = 3;
    localparam int EN_HD = 1;
    localparam int TA    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fl_req = 1'b0;
    logic          fl_we = 1'b0;
    logic [AW-1:0] fl_adr = '0;
    logic [DW-1:0] fl_wdt = '0;
    logic          fl_ack;
    logic [DW-1:0] fl_rdt;
    logic          en_req = 1'b0;
    logic          en_we = 1'b0;
    logic [AW-1:0] en_adr = '0;
    logic [DW-1:0] en_wdt = '0;
    logic [3:0]    en_be = 4'hF;
    logic          en_ack;
    logic [DW-1:0] en_rdt;
    logic [AW-1:0] ef_a;
    logic [DW-1:0] ef_d_o;
    logic          ef_d_e;
    logic [DW-1:0] ef_d_i = '0;
    logic          flash_ce_n;
    logic          flash_oe_n;
    logic          flash_we_n;
    logic          enet_rd_n;
    logic          enet_wr_n;
    logic [3:0]    enet_be_n;

    ecs8_ef_bus_ctrl #(
        .AW(AW), .DW(DW), .FL_SU(FL_SU), .FL_PW(FL_PW), .FL_HD(FL_HD),
        .EN_SU(EN_SU), .EN_PW(EN_PW), .EN_HD(EN_HD), .TA(TA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fl_req     (fl_req),
        .fl_we      (fl_we),
        .fl_adr     (fl_adr),
        .fl_wdt     (fl_wdt),
        .fl_ack     (fl_ack),
        .fl_rdt     (fl_rdt),
        .en_req     (en_req),
        .en_we      (en_we),
        .en_adr     (en_adr),
        .en_wdt     (en_wdt),
        .en_be      (en_be),
        .en_ack     (en_ack),
        .en_rdt     (en_rdt),
        .ef_a       (ef_a),
        .ef_d_o     (ef_d_o),
        .ef_d_e     (ef_d_e),
        .ef_d_i     (ef_d_i),
        .flash_ce_n (flash_ce_n),
        .flash_oe_n (flash_oe_n),
        .flash_we_n (flash_we_n),
        .enet_rd_n  (enet_rd_n),
        .enet_wr_n  (enet_wr_n),
        .enet_be_n  (enet_be_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Every pin the DUT drives, as seen in one cycle.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d_o;
        logic          d_e;
        logic          ce_n;
        logic          oe_n;
        logic          we_n;
        logic          rd_n;
        logic          wr_n;
        logic [3:0]    be_n;
        logic          fl_ack;
        logic          en_ack;
        logic [DW-1:0] fl_rdt;
        logic [DW-1:0] en_rdt;
    } pins_t;

    // Model: a granted transfer expands into its whole per-cycle pin waveform.
    pins_t         q[$];
    bit            was_idle = 1'b0;
    bit            m_last_en = 1'b1;
    logic [AW-1:0] m_a = '0;
    logic [DW-1:0] m_do = '0;
    logic [DW-1:0] m_fl_rdt = '0;
    logic [DW-1:0] m_en_rdt = '0;

    function automatic pins_t idle_pins();
        pins_t p;
        p.a = m_a; p.d_o = m_do; p.d_e = 1'b0;
        p.ce_n = 1'b1; p.oe_n = 1'b1; p.we_n = 1'b1; p.rd_n = 1'b1; p.wr_n = 1'b1;
        p.be_n = 4'hF; p.fl_ack = 1'b0; p.en_ack = 1'b0;
        p.fl_rdt = m_fl_rdt; p.en_rdt = m_en_rdt;
        return p;
    endfunction

    function automatic pins_t dut_pins();
        pins_t p;
        p.a = ef_a; p.d_o = ef_d_o; p.d_e = ef_d_e;
        p.ce_n = flash_ce_n; p.oe_n = flash_oe_n; p.we_n = flash_we_n;
        p.rd_n = enet_rd_n; p.wr_n = enet_wr_n; p.be_n = enet_be_n;
        p.fl_ack = fl_ack; p.en_ack = en_ack; p.fl_rdt = fl_rdt; p.en_rdt = en_rdt;
        return p;
    endfunction

    task automatic model_edge();
        pins_t         p;
        bit            pick_en, w, pulse;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [3:0]    b;
        int            su, pw, hd, n;
        if (rst) begin
            q.delete();
            m_last_en = 1'b1; m_a = '0; m_do = '0; m_fl_rdt = '0; m_en_rdt = '0;
        end else if (was_idle && (fl_req || en_req)) begin
            pick_en   = (fl_req && en_req) ? !m_last_en : en_req;
            m_last_en = pick_en;
            if (pick_en) begin
                w = en_we; a = en_adr; wd = en_wdt; b = en_be; su = EN_SU; pw = EN_PW; hd = EN_HD;
            end else begin
                w = fl_we; a = fl_adr; wd = fl_wdt; b = 4'hF; su = FL_SU; pw = FL_PW; hd = FL_HD;
            end
            m_a = a;
            if (w) m_do = wd;
            n = su + pw + hd;
            for (int i = 0; i < n; i++) begin
                pulse = (i >= su) && (i < su + pw);
                if (i == su + pw && !w) begin
                    if (pick_en) m_en_rdt = ef_d_i;
                    else m_fl_rdt = ef_d_i;
                end
                p = idle_pins();
                p.d_e    = w;
                p.ce_n   = pick_en;
                p.be_n   = pick_en ? ~b : 4'hF;
                p.oe_n   = !(!pick_en && !w && pulse);
                p.we_n   = !(!pick_en && w && pulse);
                p.rd_n   = !(pick_en && !w && pulse);
                p.wr_n   = !(pick_en && w && pulse);
                p.fl_ack = !pick_en && (i == n - 1);
                p.en_ack = pick_en && (i == n - 1);
                q.push_back(p);
            end
            if (!w) begin
                for (int i = 0; i < TA; i++) q.push_back(idle_pins());
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: model steps on the rising edge, all pins compared on the falling edge.
    task automatic tick();
        pins_t e, a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (q.size() != 0) begin
            e = q.pop_front();
            was_idle = 1'b0;
        end else begin
            e = idle_pins();
            was_idle = 1'b1;
        end
        a = dut_pins();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL pins @%0t: got %h expected %h", $time, a, e);
        end
    endtask

    int            t_n, t_pre, t_ce, t_st, t_de;
    logic [3:0]    t_be;
    logic [DW-1:0] t_rdt;

    // Raise a request (called at a falling edge) and follow it to its ack.
    // t_n counts the cycle in which req is first seen as cycle 1.
    task automatic txn(input bit to_en, input bit w, input logic [AW-1:0] adr,
                       input logic [DW-1:0] wd, input logic [3:0] be);
        bit started, done, active;
        started = 1'b0; done = 1'b0;
        if (to_en) begin
            en_req = 1'b1; en_we = w; en_adr = adr; en_wdt = wd; en_be = be;
        end else begin
            fl_req = 1'b1; fl_we = w; fl_adr = adr; fl_wdt = wd;
        end
        t_n = 1; t_pre = 0; t_ce = 0; t_st = 0; t_de = 0; t_be = 4'hx; t_rdt = 'x;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            t_n++;
            active = !flash_ce_n || (enet_be_n != 4'hF);
            if (!started && !active) t_pre++;
            if (active) started = 1'b1;
            t_ce += int'(!flash_ce_n);
            t_st += int'(!flash_oe_n || !flash_we_n || !enet_rd_n || !enet_wr_n);
            t_de += int'(ef_d_e);
            if (to_en ? en_ack : fl_ack) begin
                done  = 1'b1;
                t_be  = enet_be_n;
                t_rdt = to_en ? en_rdt : fl_rdt;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got no ack expected ack within 60 cycles");
        end
    endtask

    int         acks, overlap, got;
    logic [3:0] order;

    initial begin
        // Reset state.
        repeat (3) tick();
        chk("rst_strobes", {flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n}, 64'h1F);
        chk("rst_be_n", enet_be_n, 64'hF);
        chk("rst_de_ack", {ef_d_e, fl_ack, en_ack}, 64'h0);
        chk("rst_a_do", {ef_a, ef_d_o}, 64'h0);
        chk("rst_rdt", {fl_rdt, en_rdt}, 64'h0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: flash read.
        ef_d_i = 32'h0000A5A5;
        txn(1'b0, 1'b0, 26'h100, 32'h0, 4'hF);
        fl_req = 1'b0;
        chk("t1_ack_cycle", t_n, 8);
        chk("t1_ce_low", t_ce, 7);
        chk("t1_oe_low", t_st, 4);
        chk("t1_de_high", t_de, 0);
        chk("t1_rdt", t_rdt, 64'hA5A5);
        repeat (4) tick();

        // 2: ethernet write with partial byte enables.
        txn(1'b1, 1'b1, 26'h300, 32'hDEADBEEF, 4'b0011);
        en_req = 1'b0;
        chk("t2_ack_cycle", t_n, 6);
        chk("t2_de_high", t_de, 5);
        chk("t2_wr_low", t_st, 3);
        chk("t2_be_n", t_be, 64'hC);
        chk("t2_ce_low", t_ce, 0);
        repeat (3) tick();

        // 4: flash read then an immediate flash write.
        ef_d_i = 32'h0BADF00D;
        txn(1'b0, 1'b0, 26'h104, 32'h0, 4'hF);
        chk("t4_rd_rdt", t_rdt, 64'h0BADF00D);
        txn(1'b0, 1'b1, 26'h108, 32'h55AA55AA, 4'hF);
        fl_req = 1'b0;
        chk("t4_gap", t_pre, 3);
        chk("t4_wr_de", t_de, 7);
        repeat (3) tick();

        // 6: back-to-back ethernet writes.
        txn(1'b1, 1'b1, 26'h310, 32'h11112222, 4'hF);
        txn(1'b1, 1'b1, 26'h314, 32'h33334444, 4'b1000);
        en_req = 1'b0;
        chk("t6_gap", t_pre, 1);
        chk("t6_be_n", t_be, 64'h7);
        repeat (3) tick();

        // 3: both requesting from reset.
        rst = 1'b1;
        ef_d_i = 32'h00C0FFEE;
        fl_req = 1'b1; fl_we = 1'b0; fl_adr = 26'h200; fl_wdt = 32'h0;
        en_req = 1'b1; en_we = 1'b1; en_adr = 26'h320; en_wdt = 32'hFEEDFACE; en_be = 4'b0110;
        repeat (2) tick();
        rst = 1'b0;
        got = 0; order = 4'h0; overlap = 0;
        for (int k = 0; k < 100 && got < 4; k++) begin
            tick();
            if (!flash_ce_n && (!enet_rd_n || !enet_wr_n || enet_be_n != 4'hF)) overlap++;
            if (fl_ack || en_ack) begin
                order = {order[2:0], en_ack};
                got++;
            end
        end
        fl_req = 1'b0;
        en_req = 1'b0;
        chk("t3_grants", got, 4);
        chk("t3_order", order, 64'h5);
        chk("t3_overlap", overlap, 0);
        repeat (4) tick();

        // 5: reset in the middle of a flash read pulse.
        ef_d_i = 32'h12345678;
        fl_req = 1'b1; fl_we = 1'b0; fl_adr = 26'h140;
        for (int k = 0; k < 20 && flash_oe_n; k++) tick();
        chk("t5_in_pulse", flash_oe_n, 64'h0);
        rst = 1'b1;
        tick();
        chk("t5_abort_pins", {flash_oe_n, flash_ce_n, ef_d_e}, 64'h6);
        acks = int'(fl_ack);
        fl_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            acks += int'(fl_ack);
        end
        chk("t5_no_fl_ack", acks, 0);
        chk("t5_fl_rdt_cleared", fl_rdt, 64'h0);
        ef_d_i = 32'hCAFE0042;
        txn(1'b1, 1'b0, 26'h33C, 32'h0, 4'hF);
        en_req = 1'b0;
        chk("t5_en_ack_cycle", t_n, 6);
        chk("t5_en_rd_low", t_st, 3);
        chk("t5_en_rdt", t_rdt, 64'hCAFE0042);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
